// File: rtl/sdram_avalon_pattern_tester_if.sv
// Avalon-MM pipelined bus between the pattern tester (master) and the
// SDRAM controller's slave port. Signal names match the tester's original ports.
interface sdram_avalon_pattern_tester_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0]   opAddress;
  logic [DATA_WIDTH/8-1:0] opByteEnable;
  logic                    ipWaitRequest;
  logic [DATA_WIDTH-1:0]   opWriteData;
  logic                    opWrite;
  logic                    opRead;
  logic [DATA_WIDTH-1:0]   ipReadData;
  logic                    ipReadDataValid;

  modport master (
    output opAddress,
    output opByteEnable,
    input  ipWaitRequest,
    output opWriteData,
    output opWrite,
    output opRead,
    input  ipReadData,
    input  ipReadDataValid
  );

  modport slave (
    input  opAddress,
    input  opByteEnable,
    output ipWaitRequest,
    input  opWriteData,
    input  opWrite,
    input  opRead,
    output ipReadData,
    output ipReadDataValid
  );

endinterface

// File: rtl/sdram_avalon_pattern_tester.sv
// SDRAM pattern tester: writes a 16-bit Galois LFSR pattern over a word range
// through an Avalon-MM pipelined master, reads it back with up to MAX_PENDING
// outstanding reads, and counts mismatching words.
module sdram_avalon_pattern_tester #(
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic                  ipClk,
  input  logic                  ipnReset,

  input  logic                  ipStart,
  input  logic [ADDR_WIDTH-1:0] ipBaseAddress,
  input  logic [ADDR_WIDTH-1:0] ipLength,
  input  logic [15:0]           ipSeed,

  output logic                  opBusy,
  output logic                  opDone,
  output logic                  opPass,
  output logic [15:0]           opErrorCount,
  output logic [ADDR_WIDTH-1:0] opFirstErrorAddress,

  sdram_avalon_pattern_tester_if.master avalon
);

  typedef enum logic [2:0] {
    Idle,
    Write,
    Read,
    Drain,
    Done
  } stateT;

  localparam logic [ADDR_WIDTH-1:0] OneWord    = ADDR_WIDTH'(1);
  localparam logic [3:0]            PendingMax = 4'(MAX_PENDING);
  localparam logic [15:0]           LfsrTaps   = 16'hB400;
  localparam logic [15:0]           ZeroSeed   = 16'hACE1;

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LfsrTaps : 16'h0000);
  endfunction

  stateT                 state;
  stateT                 nextState;

  // Parameters of the run, sampled at start.
  logic [ADDR_WIDTH-1:0] baseReg;
  logic [ADDR_WIDTH-1:0] lenReg;
  logic [15:0]           seedReg;

  // Command path: address, pattern word and words left for the current phase.
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           lfsr;
  logic [ADDR_WIDTH-1:0] remaining;

  // Check path: tracks returned read data independently of the command path.
  logic [ADDR_WIDTH-1:0] checkAddr;
  logic [15:0]           checkLfsr;
  logic [3:0]            pending;

  logic [15:0]           errCount;
  logic [ADDR_WIDTH-1:0] firstErr;
  logic                  passReg;

  logic                  writeCmd;
  logic                  readCmd;
  logic                  wrAccept;
  logic                  rdAccept;
  logic                  validEff;
  logic                  checkStrobe;
  logic                  mismatch;
  logic [15:0]           startSeed;
  logic [DATA_WIDTH-1:0] writeWord;
  logic [DATA_WIDTH-1:0] expectedWord;

  // Zero-extend the 16-bit pattern to the bus width.
  always_comb begin
    writeWord           = '0;
    writeWord[15:0]     = lfsr;
    expectedWord        = '0;
    expectedWord[15:0]  = checkLfsr;
  end

  // Seed 0 would lock the LFSR, so it is substituted at start.
  always_comb begin
    startSeed = (ipSeed == 16'h0000) ? ZeroSeed : ipSeed;
  end

  // State register.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state <= Idle;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode and Avalon command generation.
  always_comb begin
    nextState = state;
    writeCmd  = 1'b0;
    readCmd   = 1'b0;
    unique case (state)
      Idle: begin
        if (ipStart) begin
          nextState = (ipLength == '0) ? Done : Write;
        end
      end
      Write: begin
        writeCmd = 1'b1;
        if (!avalon.ipWaitRequest && remaining == OneWord) begin
          nextState = Read;
        end
      end
      Read: begin
        readCmd = (remaining != '0) && (pending < PendingMax);
        if (readCmd && !avalon.ipWaitRequest && remaining == OneWord) begin
          nextState = Drain;
        end
      end
      Drain: begin
        if (pending == 4'd0) begin
          nextState = Done;
        end
      end
      Done: begin
        nextState = Idle;
      end
      default: begin
        nextState = Idle;
      end
    endcase
  end

  // Acceptance and check strobes; valids with nothing outstanding are dropped.
  always_comb begin
    wrAccept    = writeCmd & ~avalon.ipWaitRequest;
    rdAccept    = readCmd & ~avalon.ipWaitRequest;
    validEff    = avalon.ipReadDataValid && (pending != 4'd0);
    checkStrobe = validEff && (state == Read || state == Drain);
    mismatch    = avalon.ipReadData != expectedWord;
  end

  // Command path: sampled run parameters, address, pattern and words left.
  // The last write acceptance rewinds address/pattern so reads replay the range.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      baseReg   <= '0;
      lenReg    <= '0;
      seedReg   <= '0;
      addr      <= '0;
      lfsr      <= '0;
      remaining <= '0;
    end else if (state == Idle && ipStart) begin
      baseReg   <= ipBaseAddress;
      lenReg    <= ipLength;
      seedReg   <= startSeed;
      addr      <= ipBaseAddress;
      lfsr      <= startSeed;
      remaining <= ipLength;
    end else if (wrAccept) begin
      if (remaining == OneWord) begin
        addr      <= baseReg;
        lfsr      <= seedReg;
        remaining <= lenReg;
      end else begin
        addr      <= addr + OneWord;
        lfsr      <= lfsrNext(lfsr);
        remaining <= remaining - OneWord;
      end
    end else if (rdAccept) begin
      addr      <= addr + OneWord;
      remaining <= remaining - OneWord;
    end
  end

  // Outstanding-read counter.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      pending <= 4'd0;
    end else begin
      unique case ({rdAccept, validEff})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  // Check path: expected word/address per returned read, error accounting.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      checkAddr <= '0;
      checkLfsr <= '0;
      errCount  <= '0;
      firstErr  <= '0;
    end else if (state == Idle && ipStart) begin
      checkAddr <= ipBaseAddress;
      checkLfsr <= startSeed;
      errCount  <= '0;
      firstErr  <= '0;
    end else if (checkStrobe) begin
      checkAddr <= checkAddr + OneWord;
      checkLfsr <= lfsrNext(checkLfsr);
      if (mismatch) begin
        if (errCount != 16'hFFFF) begin
          errCount <= errCount + 16'd1;
        end
        if (errCount == 16'h0000) begin
          firstErr <= checkAddr;
        end
      end
    end
  end

  // Pass flag: cleared at start (set for an empty run), resolved entering Done.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      passReg <= 1'b0;
    end else if (state == Idle && ipStart) begin
      passReg <= (ipLength == '0);
    end else if (state == Drain && nextState == Done) begin
      passReg <= (errCount == 16'h0000);
    end
  end

  // Status and bus outputs; the bus idles at zero outside active commands.
  always_comb begin
    opBusy              = (state == Write) || (state == Read) || (state == Drain);
    opDone              = (state == Done);
    opPass              = passReg;
    opErrorCount        = errCount;
    opFirstErrorAddress = firstErr;
    avalon.opAddress    = (writeCmd || readCmd) ? addr : '0;
    avalon.opWriteData  = writeCmd ? writeWord : '0;
    avalon.opWrite      = writeCmd;
    avalon.opRead       = readCmd;
    avalon.opByteEnable = '1;
  end

endmodule

// File: tb/tb_sdram_avalon_pattern_tester.sv
// Bench for sdram_avalon_pattern_tester: behavioural SDRAM slave with
// configurable latency, waitrequest stalls, corrupted words and spurious valids;
// expectations come from the pattern definition applied to each run.
module tb_sdram_avalon_pattern_tester;

  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int MAXP = 8;

  logic          ipClk = 1'b0;
  logic          ipnReset = 1'b0;
  logic          ipStart = 1'b0;
  logic [AW-1:0] ipBaseAddress = '0;
  logic [AW-1:0] ipLength = '0;
  logic [15:0]   ipSeed = '0;
  logic          opBusy;
  logic          opDone;
  logic          opPass;
  logic [15:0]   opErrorCount;
  logic [AW-1:0] opFirstErrorAddress;

  sdram_avalon_pattern_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) avalon ();

  sdram_avalon_pattern_tester #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_PENDING(MAXP)
  ) dut (
    .ipClk              (ipClk),
    .ipnReset           (ipnReset),
    .ipStart            (ipStart),
    .ipBaseAddress      (ipBaseAddress),
    .ipLength           (ipLength),
    .ipSeed             (ipSeed),
    .opBusy             (opBusy),
    .opDone             (opDone),
    .opPass             (opPass),
    .opErrorCount       (opErrorCount),
    .opFirstErrorAddress(opFirstErrorAddress),
    .avalon             (avalon)
  );

  always #5 ipClk = ~ipClk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Word k of the pattern: k LFSR steps from the (substituted) seed.
  function automatic logic [15:0] patternWord(input logic [15:0] seed, input int unsigned k);
    logic [15:0] s;
    s = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int unsigned i = 0; i < k; i++) begin
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
    return s;
  endfunction

  // Slave configuration for the current run.
  logic [AW-1:0] cfgBase = '0;
  logic [15:0]   cfgSeed = '0;
  int unsigned   latency = 1;
  int unsigned   waitPct = 0;
  bit            scripted = 0;
  bit            corruptEn = 0;
  logic [AW-1:0] corruptA = '0;
  logic [AW-1:0] corruptB = '0;
  bit            spuriousEn = 0;

  // Slave observations.
  int unsigned   wIdx = 0;
  int unsigned   rIdx = 0;
  int unsigned   vIdx = 0;
  int unsigned   tbOut = 0;
  int unsigned   maxOut = 0;
  int unsigned   stallCnt = 0;
  int unsigned   cycle = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   due;
  } rdReqT;
  rdReqT         rdQ[$];
  logic [15:0]   mem [logic [AW-1:0]];

  bit            stallValid = 0;
  logic [1:0]    stallCmd;
  logic [AW-1:0] stallAddr;
  logic [DW-1:0] stallData;
  bit            waitNow;
  rdReqT         head;

  // Memory model: decides waitrequest, records accepted commands and returns
  // read data in order after the configured latency. Runs on the falling edge so
  // everything it drives is stable for the DUT's next rising edge.
  always @(negedge ipClk) begin
    cycle++;
    if (!ipnReset) begin
      rdQ.delete();
      tbOut = 0;
      stallValid = 0;
      avalon.ipWaitRequest = 1'b0;
      avalon.ipReadDataValid = 1'b0;
      avalon.ipReadData = '0;
    end else begin
      if (stallValid) begin
        checkValue("holdCmd", {avalon.opWrite, avalon.opRead}, stallCmd);
        checkValue("holdAddr", avalon.opAddress, stallAddr);
        if (stallCmd[1]) checkValue("holdData", avalon.opWriteData, stallData);
      end
      if (avalon.opWrite || avalon.opRead)
        checkValue("cmdExclusive", avalon.opWrite & avalon.opRead, 0);

      if (scripted) waitNow = avalon.opWrite && (wIdx == 1) && (stallCnt < 3);
      else          waitNow = ($urandom_range(99) < waitPct);
      if (scripted && waitNow) begin
        stallCnt++;
        checkValue("stallAddr", avalon.opAddress, AW'(cfgBase + 1));
        checkValue("stallData", avalon.opWriteData, patternWord(cfgSeed, 1));
      end
      avalon.ipWaitRequest = waitNow;
      stallValid = waitNow && (avalon.opWrite || avalon.opRead);
      stallCmd   = {avalon.opWrite, avalon.opRead};
      stallAddr  = avalon.opAddress;
      stallData  = avalon.opWriteData;

      if (tbOut >= MAXP) checkValue("readWhileFull", avalon.opRead, 0);

      if (!waitNow && avalon.opWrite) begin
        checkValue("wrAddr", avalon.opAddress, AW'(cfgBase + wIdx));
        checkValue("wrData", avalon.opWriteData, patternWord(cfgSeed, wIdx));
        mem[avalon.opAddress] = avalon.opWriteData;
        wIdx++;
      end
      if (!waitNow && avalon.opRead) begin
        checkValue("rdAddr", avalon.opAddress, AW'(cfgBase + rIdx));
        rdQ.push_back('{addr: avalon.opAddress, due: cycle + latency});
        rIdx++;
        tbOut++;
        if (tbOut > maxOut) maxOut = tbOut;
      end

      avalon.ipReadDataValid = 1'b0;
      avalon.ipReadData = '0;
      if (rdQ.size() != 0 && rdQ[0].due <= cycle) begin
        head = rdQ.pop_front();
        avalon.ipReadDataValid = 1'b1;
        avalon.ipReadData = mem.exists(head.addr) ? mem[head.addr] : 16'h0000;
        if (corruptEn && (head.addr == corruptA || head.addr == corruptB))
          avalon.ipReadData[0] = ~avalon.ipReadData[0];
        tbOut--;
        vIdx++;
      end else if (spuriousEn && tbOut == 0 && $urandom_range(3) == 0) begin
        avalon.ipReadDataValid = 1'b1;
        avalon.ipReadData = 16'($urandom);
      end
    end
  end

  task automatic runTest(input logic [AW-1:0] base, input int unsigned len, input logic [15:0] seed,
                         input int unsigned lat, input int unsigned wp, input bit scr,
                         input bit cEn, input logic [AW-1:0] cA, input logic [AW-1:0] cB,
                         input bit pokeBusy, input bit pokeDone);
    int unsigned   expErr;
    logic [AW-1:0] expFirst;
    logic [AW-1:0] a;
    bit            done;
    expErr = 0;
    expFirst = '0;
    for (int unsigned k = 0; k < len; k++) begin
      a = AW'(base + k);
      if (cEn && (a == cA || a == cB)) begin
        if (expErr == 0) expFirst = a;
        expErr++;
      end
    end

    @(negedge ipClk);
    cfgBase = base; cfgSeed = seed; latency = lat; waitPct = wp; scripted = scr;
    corruptEn = cEn; corruptA = cA; corruptB = cB;
    wIdx = 0; rIdx = 0; vIdx = 0; maxOut = 0; stallCnt = 0;
    ipStart = 1'b1; ipBaseAddress = base; ipLength = AW'(len); ipSeed = seed;
    @(negedge ipClk);
    ipStart = 1'b0;

    if (len == 0) begin
      checkValue("zeroLenDone", opDone, 1);
      checkValue("zeroLenPass", opPass, 1);
      checkValue("zeroLenBusy", opBusy, 0);
      @(negedge ipClk);
      checkValue("zeroLenTraffic", wIdx + rIdx, 0);
      checkValue("zeroLenPulse", opDone, 0);
      return;
    end

    checkValue("busyAfterStart", opBusy, 1);
    done = 0;
    for (int i = 0; i < 5000; i++) begin
      if (opDone) begin
        done = 1;
        break;
      end
      if (pokeBusy) begin
        ipStart = (i == 3);
        if (i == 3) begin
          ipBaseAddress = AW'($urandom);
          ipLength = AW'(0);
          ipSeed = 16'($urandom);
        end
      end
      @(negedge ipClk);
    end
    ipStart = 1'b0;
    checkValue("doneSeen", done, 1);
    if (!done) return;

    checkValue("busyAtDone", opBusy, 0);
    checkValue("pass", opPass, (expErr == 0));
    checkValue("errorCount", opErrorCount, expErr);
    checkValue("firstErrAddr", opFirstErrorAddress, expFirst);
    checkValue("writeCount", wIdx, len);
    checkValue("readCount", rIdx, len);
    checkValue("validCount", vIdx, len);
    checkValue("pendingBound", (maxOut <= MAXP), 1);
    if (scr) checkValue("stallCycles", stallCnt, 3);

    if (pokeDone) ipStart = 1'b1;
    @(negedge ipClk);
    ipStart = 1'b0;
    checkValue("donePulse", opDone, 0);
    checkValue("idleAfterDone", opBusy, 0);
    checkValue("passHeld", opPass, (expErr == 0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, "Busy"}, opBusy, 0);
    checkValue({tag, "Done"}, opDone, 0);
    checkValue({tag, "Pass"}, opPass, 0);
    checkValue({tag, "ErrCnt"}, opErrorCount, 0);
    checkValue({tag, "FirstErr"}, opFirstErrorAddress, 0);
    checkValue({tag, "Addr"}, avalon.opAddress, 0);
    checkValue({tag, "WrData"}, avalon.opWriteData, 0);
    checkValue({tag, "Cmd"}, {avalon.opWrite, avalon.opRead}, 0);
    checkValue({tag, "ByteEn"}, avalon.opByteEnable, 2'b11);
  endtask

  initial begin
    logic [AW-1:0] base;
    int unsigned   len;
    bit            hit;

    repeat (2) @(negedge ipClk);
    checkResetOutputs("reset");
    ipnReset = 1'b1;

    // Basic run with a start request coinciding with opDone.
    runTest(AW'(0), 4, 16'h0001, 1, 0, 0, 0, '0, '0, 0, 1);
    // Three-cycle stall on the second write.
    runTest(AW'(0), 4, 16'h0001, 1, 0, 1, 0, '0, '0, 0, 0);
    // Long latency fills the read pipeline.
    runTest(AW'(0), 32, 16'h1234, 10, 0, 0, 0, '0, '0, 0, 0);
    checkValue("pipelineFilled", maxOut, MAXP);
    // Two corrupted words, then spurious valids while idle must change nothing.
    runTest(AW'(0), 16, 16'h0001, 3, 0, 0, 1, AW'(5), AW'(9), 0, 0);
    spuriousEn = 1;
    repeat (12) @(negedge ipClk);
    spuriousEn = 0;
    checkValue("spuriousErrCnt", opErrorCount, 2);
    checkValue("spuriousFirstErr", opFirstErrorAddress, 5);
    checkValue("spuriousBusy", opBusy, 0);
    // Range wrapping past the top address.
    runTest(AW'(33554430), 4, 16'hBEEF, 2, 0, 0, 0, '0, '0, 0, 0);
    // Empty run and zero-seed substitution.
    runTest(AW'(77), 0, 16'h0001, 1, 0, 0, 0, '0, '0, 0, 0);
    runTest(AW'(40), 6, 16'h0000, 2, 20, 0, 0, '0, '0, 0, 0);

    // Reset asserted with three reads outstanding.
    @(negedge ipClk);
    cfgBase = AW'(100); cfgSeed = 16'h5A5A; latency = 20; waitPct = 0; scripted = 0; corruptEn = 0;
    wIdx = 0; rIdx = 0; vIdx = 0; maxOut = 0;
    ipStart = 1'b1; ipBaseAddress = AW'(100); ipLength = AW'(32); ipSeed = 16'h5A5A;
    @(negedge ipClk);
    ipStart = 1'b0;
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      if (tbOut == 3) begin
        hit = 1;
        break;
      end
      @(negedge ipClk);
    end
    checkValue("reachedThreePending", hit, 1);
    #1 ipnReset = 1'b0;
    #1 checkResetOutputs("midRunReset");
    repeat (3) @(negedge ipClk);
    checkResetOutputs("heldReset");
    ipnReset = 1'b1;
    runTest(AW'(200), 12, 16'h0F0F, 4, 10, 0, 0, '0, '0, 0, 0);

    // Randomized runs.
    spuriousEn = 1;
    for (int n = 0; n < 8; n++) begin
      base = AW'($urandom);
      if (n == 0) base = AW'(33554432 - 3);
      len = $urandom_range(40, 1);
      runTest(base, len, ($urandom_range(4) == 0) ? 16'h0000 : 16'($urandom),
              $urandom_range(12, 1), $urandom_range(40), 0,
              $urandom_range(1), AW'(base + $urandom_range(len - 1)), AW'(base + $urandom_range(len - 1)),
              (len >= 8) && ($urandom_range(1) == 1), $urandom_range(1));
    end
    spuriousEn = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
